req_ack_arbiter: RTL and testbench



---
 rtl/req_ack_arbiter.sv | 98 +++++++++
 tb/tb_req_ack_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin sharing of one downstream req/ack channel with response timeout
module req_ack_arbiter #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 32,
    parameter int RDATA_W     = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           up_req,
    input  logic [N_REQ*DATA_W-1:0]    up_data,
    output logic [N_REQ-1:0]           up_ack,
    output logic [RDATA_W-1:0]         up_rdata,
    output logic                       dn_req,
    output logic [DATA_W-1:0]          dn_data,
    input  logic                       dn_ack,
    input  logic [RDATA_W-1:0]         dn_rdata,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_timeout
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
    state_t state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic found;
    logic [DATA_W-1:0] win_data;
    logic [CW-1:0] cnt;
    logic tmo;
    assign tmo = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));
    // first requester found searching upward from the slot after the last winner
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        win_data = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(ptr) + k) % N_REQ);
            if (!found && up_req[idx]) begin
                found = 1'b1;
                win = idx;
                win_data = up_data[idx*DATA_W +: DATA_W];
            end
        end
    end
    // IDLE -> REQ -> ACK sequencing with every output registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= GW'(N_REQ - 1);
            cnt <= '0;
            up_ack <= '0;
            up_rdata <= '0;
            dn_req <= 1'b0;
            dn_data <= '0;
            grant_id <= '0;
            busy <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            up_ack <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    grant_id <= win;
                    ptr <= win;
                    dn_data <= win_data;
                    dn_req <= 1'b1;
                    busy <= 1'b1;
                    cnt <= '0;
                    state <= REQ;
                end
                REQ: begin
                    cnt <= (&cnt) ? cnt : cnt + 1'b1;
                    if (dn_ack || tmo) begin
                        up_rdata <= dn_ack ? dn_rdata : '0;
                        err_timeout <= !dn_ack;
                        up_ack <= N_REQ'(1) << grant_id;
                        dn_req <= 1'b0;
                        state <= ACK;
                    end
                end
                ACK: begin
                    cnt <= '0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    dn_req <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_req_ack_arbiter.sv
// tb_req_ack_arbiter: directed stimulus with a queue-based completion scoreboard
module tb_req_ack_arbiter;
    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        gid;
        logic        err;
        int          gap;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  up_req = '0;
    logic [63:0] up_data = '0;
    logic [1:0]  up_ack;
    logic [31:0] up_rdata;
    logic        dn_req;
    logic [31:0] dn_data;
    logic        dn_ack = 1'b0;
    logic [31:0] dn_rdata = '0;
    logic        grant_id;
    logic        busy;
    logic        err_timeout;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_ack = 0;
    exp_t q[$];
    exp_t e;

    req_ack_arbiter #(.N_REQ(2), .DATA_W(32), .RDATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .up_req(up_req), .up_data(up_data), .up_ack(up_ack),
        .up_rdata(up_rdata), .dn_req(dn_req), .dn_data(dn_data), .dn_ack(dn_ack),
        .dn_rdata(dn_rdata), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ack, input logic [31:0] rdata, input logic gid, input logic err, input int gap);
        exp_t x;
        x.ack = ack;
        x.rdata = rdata;
        x.gid = gid;
        x.err = err;
        x.gap = gap;
        q.push_back(x);
    endtask

    // completion monitor: every up_ack pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (up_ack !== 2'b00) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ack: got up_ack=%b expected none", up_ack);
            end else begin
                e = q.pop_front();
                chk("up_ack", 64'(up_ack), 64'(e.ack));
                chk("up_rdata", 64'(up_rdata), 64'(e.rdata));
                chk("grant_id_at_ack", 64'(grant_id), 64'(e.gid));
                chk("err_timeout", 64'(err_timeout), 64'(e.err));
                if (e.gap > 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
            end
            last_ack = cyc;
        end else if (err_timeout !== 1'b0) begin
            chk("err_without_ack", 64'(err_timeout), 64'd0);
        end
    end

    initial begin
        // reset values
        tick();
        tick();
        chk("rst_up_ack", 64'(up_ack), 64'd0);
        chk("rst_up_rdata", 64'(up_rdata), 64'd0);
        chk("rst_dn_req", 64'(dn_req), 64'd0);
        chk("rst_dn_data", 64'(dn_data), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        // single requester 1 transaction
        rst = 1'b0;
        up_req = 2'b10;
        up_data[63:32] = 32'hA5;
        push(2'b10, 32'h5A, 1'b1, 1'b0, 0);
        tick();
        chk("t1_dn_req", 64'(dn_req), 64'd1);
        chk("t1_dn_data", 64'(dn_data), 64'hA5);
        chk("t1_grant_id", 64'(grant_id), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        dn_ack = 1'b1;
        dn_rdata = 32'h5A;
        tick();
        chk("t1_dn_req_drop", 64'(dn_req), 64'd0);
        dn_ack = 1'b0;
        up_req = 2'b00;
        tick();
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        // both held after reset, dn_ack tied high: 0,1,0,1 every 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        up_req = 2'b11;
        dn_ack = 1'b1;
        dn_rdata = 32'hC0DE;
        push(2'b01, 32'hC0DE, 1'b0, 1'b0, 0);
        push(2'b10, 32'hC0DE, 1'b1, 1'b0, 3);
        push(2'b01, 32'hC0DE, 1'b0, 1'b0, 3);
        push(2'b10, 32'hC0DE, 1'b1, 1'b0, 3);
        repeat (11) tick();
        up_req = 2'b00;
        dn_ack = 1'b0;
        tick();
        chk("t2_all_done", 64'(q.size()), 64'd0);
        // timeout: requester 0, no dn_ack
        up_req = 2'b01;
        up_data[31:0] = 32'h77;
        dn_rdata = 32'hDEAD;
        push(2'b01, 32'h0, 1'b0, 1'b1, 0);
        tick();
        chk("t4_dn_req", 64'(dn_req), 64'd1);
        chk("t4_dn_data", 64'(dn_data), 64'h77);
        repeat (7) tick();
        chk("t4_dn_req_8th", 64'(dn_req), 64'd1);
        tick();
        chk("t4_dn_req_drop", 64'(dn_req), 64'd0);
        up_req = 2'b00;
        tick();
        dn_ack = 1'b1;
        dn_rdata = 32'hBAD;
        tick();
        dn_ack = 1'b0;
        tick();
        chk("t4_late_busy", 64'(busy), 64'd0);
        chk("t4_late_dn_req", 64'(dn_req), 64'd0);
        chk("t4_late_rdata", 64'(up_rdata), 64'd0);
        // dn_ack on the timeout cycle wins; requester drops and data changes mid-REQ
        up_req = 2'b10;
        up_data[63:32] = 32'h1234;
        dn_rdata = 32'hBEEF;
        push(2'b10, 32'hBEEF, 1'b1, 1'b0, 0);
        tick();
        chk("t5_grant_id", 64'(grant_id), 64'd1);
        chk("t5_dn_data", 64'(dn_data), 64'h1234);
        up_req = 2'b00;
        up_data[63:32] = 32'hFFFF;
        tick();
        chk("t5_dn_data_frozen", 64'(dn_data), 64'h1234);
        repeat (6) tick();
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t5_dn_req_drop", 64'(dn_req), 64'd0);
        tick();
        // reset mid-REQ, then re-grant from the reset pointer
        up_req = 2'b01;
        tick();
        chk("t6_dn_req", 64'(dn_req), 64'd1);
        rst = 1'b1;
        up_req = 2'b11;
        tick();
        chk("t6_rst_dn_req", 64'(dn_req), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_up_ack", 64'(up_ack), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_regrant_id", 64'(grant_id), 64'd0);
        chk("t6_regrant_req", 64'(dn_req), 64'd1);
        push(2'b01, 32'h4242, 1'b0, 1'b0, 0);
        dn_ack = 1'b1;
        dn_rdata = 32'h4242;
        tick();
        dn_ack = 1'b0;
        up_req = 2'b00;
        repeat (3) tick();
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
